// File: rtl/cb_wb_arbiter.sv
// cb_wb_arbiter: shares the completion-buffer result write port between
// NUM_REQ functional units. Each unit owns a one-entry skid register. A
// round-robin arbiter picks one full skid per cycle and registers it into
// the wb_* output stage. A flush drops every pending result.
//
// Handshake: a unit transfers a result on a cycle where req_valid[i] and
// req_ready[i] are both high at the rising CLK edge. req_ready[i] depends
// only on skid state, the grant and flush, never on req_valid. wb_valid is
// a one-cycle write strobe with no backpressure from the completion buffer.
module cb_wb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 4,
  parameter int DATA_W  = 32,
  localparam int SRC_W  = $clog2(NUM_REQ)
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*IDX_W-1:0]  req_index,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ*5-1:0]      req_vd,
  input  logic [NUM_REQ-1:0]        req_exception,
  input  logic [NUM_REQ-1:0]        req_wen,
  output logic                      wb_valid,
  output logic [IDX_W-1:0]          wb_index,
  output logic [DATA_W-1:0]         wb_data,
  output logic [4:0]                wb_vd,
  output logic                      wb_exception,
  output logic                      wb_wen,
  output logic [SRC_W-1:0]          wb_src
);

  // Skid registers, one entry per unit.
  logic [NUM_REQ-1:0] skid_v;
  logic [IDX_W-1:0]   skid_index [NUM_REQ];
  logic [DATA_W-1:0]  skid_data  [NUM_REQ];
  logic [4:0]         skid_vd    [NUM_REQ];
  logic [NUM_REQ-1:0] skid_exc;
  logic [NUM_REQ-1:0] skid_wen;

  // Arbitration state and decisions.
  logic [SRC_W-1:0]   rr_ptr;
  logic [SRC_W-1:0]   rr_next;
  logic [SRC_W-1:0]   grant_idx;
  logic [SRC_W-1:0]   scan_idx;
  logic               grant_any;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] accept;

  // Round-robin search: first full skid at or after rr_ptr, wrapping.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = SRC_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!grant_any && skid_v[scan_idx]) begin
        grant_any = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  assign grant   = grant_any ? (NUM_REQ'(1) << grant_idx) : '0;
  assign rr_next = (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx + SRC_W'(1);

  // A skid being drained this cycle can be refilled in the same cycle, so a
  // single unit streams at one result per cycle.
  assign req_ready = ~{NUM_REQ{flush}} & (~skid_v | grant);
  assign accept    = req_valid & req_ready;

  // Skid update: flush clears, accept loads (even when granted), grant clears.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      skid_v   <= '0;
      skid_exc <= '0;
      skid_wen <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        skid_index[i] <= '0;
        skid_data[i]  <= '0;
        skid_vd[i]    <= '0;
      end
    end else if (flush) begin
      skid_v <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept[i]) begin
          skid_v[i]     <= 1'b1;
          skid_index[i] <= req_index[i*IDX_W +: IDX_W];
          skid_data[i]  <= req_data[i*DATA_W +: DATA_W];
          skid_vd[i]    <= req_vd[i*5 +: 5];
          skid_exc[i]   <= req_exception[i];
          skid_wen[i]   <= req_wen[i];
        end else if (grant[i]) begin
          skid_v[i] <= 1'b0;
        end
      end
    end
  end

  // Output stage and round-robin pointer; a grant during flush is discarded.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wb_valid     <= 1'b0;
      wb_index     <= '0;
      wb_data      <= '0;
      wb_vd        <= '0;
      wb_exception <= 1'b0;
      wb_wen       <= 1'b0;
      wb_src       <= '0;
      rr_ptr       <= '0;
    end else if (flush) begin
      wb_valid     <= 1'b0;
      wb_exception <= 1'b0;
      wb_wen       <= 1'b0;
      rr_ptr       <= '0;
    end else if (grant_any) begin
      wb_valid     <= 1'b1;
      wb_index     <= skid_index[grant_idx];
      wb_data      <= skid_data[grant_idx];
      wb_vd        <= skid_vd[grant_idx];
      wb_exception <= skid_exc[grant_idx];
      wb_wen       <= skid_wen[grant_idx] & ~skid_exc[grant_idx];
      wb_src       <= grant_idx;
      rr_ptr       <= rr_next;
    end else begin
      wb_valid     <= 1'b0;
      wb_exception <= 1'b0;
      wb_wen       <= 1'b0;
    end
  end

endmodule
